// File: rtl/vga_timing_gen.sv
// VGA raster generator: free-running h/v counters decode x, y, active and
// frame_start; colour and syncs leave through one aligned register stage.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk_25M,
  input  logic        reset,
  input  logic [11:0] color,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        frame_start,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS        = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS        = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign active      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_start = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

  // Blanking forces black so the monitor sees 0 V outside the visible area.
  always_comb begin
    rgb_d   = active ? color : 12'h000;
    hsync_d = ((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values together, independent of statement order.
  always_ff @(posedge clk_25M or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rgb_q   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a shrunken
// SYNC_POL=1 instance, both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit pol;
  } geom_t;

  typedef struct {
    int         x, y;
    bit         active, fs;
    logic [11:0] rgb;
    bit         hs, vs;
  } exp_t;

  localparam geom_t GA = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, pol:1'b0};
  localparam geom_t GB = '{ha:8,   hfp:2,  hsw:3,  hbp:3,  va:6,   vfp:2,  vsw:2, vbp:2,  pol:1'b1};

  logic        clk_25M = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] color   = 12'h000;

  logic [10:0] x_a, y_a, x_b, y_b;
  logic        active_a, fs_a, hsync_a, vsync_a;
  logic        active_b, fs_b, hsync_b, vsync_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  logic [11:0] prev_color = 12'h000;
  int last_fs_b = -1;
  int hs_low_a  = 0;

  always #20 clk_25M = ~clk_25M;

  vga_timing_gen dut_a (
    .clk_25M(clk_25M), .reset(reset), .color(color),
    .x(x_a), .y(y_a), .active(active_a), .frame_start(fs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .hsync(hsync_a), .vsync(vsync_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk_25M(clk_25M), .reset(reset), .color(color),
    .x(x_b), .y(y_b), .active(active_b), .frame_start(fs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hsync(hsync_b), .vsync(vsync_b)
  );

  function automatic int h_total(geom_t g);
    return g.ha + g.hfp + g.hsw + g.hbp;
  endfunction

  function automatic int v_total(geom_t g);
    return g.va + g.vfp + g.vsw + g.vbp;
  endfunction

  // Expected view at cycle t after reset release; registered outputs reflect cycle t-1.
  function automatic exp_t exp_at(geom_t g, int tc, logic [11:0] pc);
    exp_t e;
    int ht, vt, px, py;
    ht = h_total(g);
    vt = v_total(g);
    e.x      = tc % ht;
    e.y      = (tc / ht) % vt;
    e.active = (e.x < g.ha) && (e.y < g.va);
    e.fs     = (e.x == 0) && (e.y == 0);
    if (tc == 0) begin
      e.rgb = 12'h000;
      e.hs  = !g.pol;
      e.vs  = !g.pol;
    end else begin
      px    = (tc - 1) % ht;
      py    = ((tc - 1) / ht) % vt;
      e.rgb = ((px < g.ha) && (py < g.va)) ? pc : 12'h000;
      e.hs  = (px >= g.ha + g.hfp && px < g.ha + g.hfp + g.hsw) ? g.pol : !g.pol;
      e.vs  = (py >= g.va + g.vfp && py < g.va + g.vfp + g.vsw) ? g.pol : !g.pol;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = exp_at(GA, t, prev_color);
    eb = exp_at(GB, t, prev_color);
    check("a.x",      32'(x_a),                 32'(ea.x));
    check("a.y",      32'(y_a),                 32'(ea.y));
    check("a.active", 32'(active_a),            32'(ea.active));
    check("a.fs",     32'(fs_a),                32'(ea.fs));
    check("a.rgb",    32'({r_a, g_a, b_a}),     32'(ea.rgb));
    check("a.hsync",  32'(hsync_a),             32'(ea.hs));
    check("a.vsync",  32'(vsync_a),             32'(ea.vs));
    check("b.x",      32'(x_b),                 32'(eb.x));
    check("b.y",      32'(y_b),                 32'(eb.y));
    check("b.active", 32'(active_b),            32'(eb.active));
    check("b.fs",     32'(fs_b),                32'(eb.fs));
    check("b.rgb",    32'({r_b, g_b, b_b}),     32'(eb.rgb));
    check("b.hsync",  32'(hsync_b),             32'(eb.hs));
    check("b.vsync",  32'(vsync_b),             32'(eb.vs));
  endtask

  // Runs n cycles, checking at each falling edge and then driving a new colour.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_all();
      if (fs_b === 1'b1) begin
        if (last_fs_b >= 0)
          check("b.frame_period", 32'(t - last_fs_b), 32'(h_total(GB) * v_total(GB)));
        last_fs_b = t;
      end
      if (t >= 1 && t <= h_total(GA) && hsync_a === 1'b0) hs_low_a++;
      color = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
      prev_color = color;
      @(posedge clk_25M);
      @(negedge clk_25M);
      t++;
    end
  endtask

  task automatic check_reset_values();
    check("rst.a.x",     32'(x_a),             32'd0);
    check("rst.a.y",     32'(y_a),             32'd0);
    check("rst.a.fs",    32'(fs_a),            32'd1);
    check("rst.a.rgb",   32'({r_a, g_a, b_a}), 32'd0);
    check("rst.a.hsync", 32'(hsync_a),         32'd1);
    check("rst.a.vsync", 32'(vsync_a),         32'd1);
    check("rst.b.x",     32'(x_b),             32'd0);
    check("rst.b.rgb",   32'({r_b, g_b, b_b}), 32'd0);
    check("rst.b.hsync", 32'(hsync_b),         32'd0);
    check("rst.b.vsync", 32'(vsync_b),         32'd0);
  endtask

  initial begin
    // Reset held across five edges with a non-black colour on the input.
    color = 12'hF0F;
    repeat (5) @(posedge clk_25M);
    @(negedge clk_25M);
    check_reset_values();

    reset = 1'b0;
    t = 0;
    last_fs_b = -1;
    run_cycles(h_total(GA) + 300);
    check("a.hsync_low_cycles_line0", 32'(hs_low_a), 32'(GA.hsw));
    check("a.x_before_async_reset",   32'(x_a),      32'd300);
    check("a.y_before_async_reset",   32'(y_a),      32'd1);

    // Asynchronous reset between clock edges must act without a clock edge.
    #5 reset = 1'b1;
    #1 check_reset_values();
    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    check_reset_values();

    reset = 1'b0;
    t = 0;
    last_fs_b = -1;
    run_cycles(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10ms;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
